// File: rtl/packConv.sv
// packConv: shared defaults, legacy fixed-size typedefs and post-MAC scaling for conv blocks
package packConv;
  localparam int NBITS_DEF = 16;
  localparam int FRAC_BITS_DEF = 8;
  typedef logic signed [NBITS_DEF-1:0] param25 [25];
  typedef logic signed [NBITS_DEF-1:0] param9 [9];
  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} conv_state_t;
  // Drop fractional weight bits (floor), optional ReLU, clamp to nbits signed range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc, input int frac,
                                                   input int nbits, input logic relu);
    logic signed [63:0] r, hi, lo;
    hi = (64'sd1 <<< (nbits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r = acc >>> frac;
    r = (relu && r < 64'sd0) ? 64'sd0 : r;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/conv_mac_sat.sv
// conv_mac_sat: accumulator with signed multiplier and shift/ReLU/saturate result path
module conv_mac_sat import packConv::*; #(
  parameter int NBITS = NBITS_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W = 2 * NBITS + 5
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    relu,
  input  logic signed [NBITS-1:0] x,
  input  logic signed [NBITS-1:0] w,
  output logic signed [NBITS-1:0] res
);
  logic signed [2*NBITS-1:0] prod;
  logic signed [ACC_W-1:0] acc;
  always_comb prod = (2 * NBITS)'(x) * (2 * NBITS)'(w);
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + ACC_W'(prod);
  always_comb res = NBITS'(sat_shift(64'(acc), FRAC_BITS, NBITS, relu));
endmodule

// File: rtl/conv_multichannel.sv
// conv_multichannel: multi-channel valid-mode 2-D convolution on one time-multiplexed MAC
module conv_multichannel import packConv::*; #(
  parameter int NBITS = NBITS_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int IMG = 5,
  parameter int K = 3,
  parameter int CH = 1
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    relu_en,
  input  logic signed [NBITS-1:0] inputMAP [CH][IMG*IMG],
  input  logic signed [NBITS-1:0] weights [CH][K*K],
  output logic signed [NBITS-1:0] outputMAP [(IMG-K+1)*(IMG-K+1)],
  output logic                    data_valid,
  output logic                    busy
);
  localparam int OUT = IMG - K + 1;
  localparam int ACC_W = 2 * NBITS + $clog2(CH * K * K) + 1;
  localparam int XW = IMG > 1 ? $clog2(IMG) : 1;
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  localparam int IW = IMG * IMG > 1 ? $clog2(IMG * IMG) : 1;
  localparam int TW = K * K > 1 ? $clog2(K * K) : 1;
  localparam int OW = OUT * OUT > 1 ? $clog2(OUT * OUT) : 1;
  conv_state_t state, nxt;
  logic [XW-1:0] px, py, tx, ty;
  logic [CW-1:0] c;
  logic [IW-1:0] xi;
  logic [TW-1:0] wi;
  logic [OW-1:0] pi;
  logic signed [NBITS-1:0] xr [CH][IMG*IMG];
  logic signed [NBITS-1:0] wr [CH][K*K];
  logic signed [NBITS-1:0] res;
  logic relu_r, tx_last, ty_last, c_last, mac_last, px_last, pix_last;
  always_comb begin
    xi = IW'(py + ty) * IW'(IMG) + IW'(px) + IW'(tx);
    wi = TW'(ty) * TW'(K) + TW'(tx);
    pi = OW'(py) * OW'(OUT) + OW'(px);
    tx_last = tx == XW'(K - 1);
    ty_last = ty == XW'(K - 1);
    c_last = c == CW'(CH - 1);
    mac_last = tx_last && ty_last && c_last;
    px_last = px == XW'(OUT - 1);
    pix_last = px_last && py == XW'(OUT - 1);
    nxt = state;
    case (state)
      IDLE:    nxt = start ? MAC : IDLE;
      MAC:     nxt = mac_last ? WRITE : MAC;
      WRITE:   nxt = pix_last ? DONE : MAC;
      default: nxt = IDLE;
    endcase
  end
  // Operand snapshot lets the caller change inputs as soon as start is accepted.
  always_ff @(posedge clk)
    if (state == IDLE && start) begin
      xr <= inputMAP;
      wr <= weights;
      relu_r <= relu_en;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {px, py, tx, ty, c} <= '0;
      outputMAP <= '{default: '0};
      data_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      data_valid <= state == DONE;
      busy <= nxt != IDLE || state == DONE;
      if (state == IDLE) {px, py, tx, ty, c} <= '0;
      if (state == MAC) begin
        tx <= tx_last ? '0 : tx + 1'b1;
        ty <= tx_last ? (ty_last ? '0 : ty + 1'b1) : ty;
        c <= tx_last && ty_last ? (c_last ? '0 : c + 1'b1) : c;
      end
      if (state == WRITE) begin
        outputMAP[pi] <= res;
        px <= px_last ? '0 : px + 1'b1;
        py <= px_last ? py + 1'b1 : py;
      end
    end
  conv_mac_sat #(.NBITS(NBITS), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .reset(reset),
    .clr(state == IDLE || state == WRITE),
    .en(state == MAC),
    .relu(relu_r),
    .x(xr[c][xi]),
    .w(wr[c][wi]),
    .res(res)
  );
endmodule

// File: tb/tb_conv_multichannel.sv
// tb_conv_multichannel: random and directed checks of single- and dual-channel convolvers against a direct model
module tb_conv_multichannel;
  logic clk = 0, reset = 0, start1 = 0, start2 = 0, relu1 = 0, relu2 = 0;
  logic signed [15:0] map1 [1][25];
  logic signed [15:0] w1 [1][9];
  logic signed [15:0] out1 [9];
  logic signed [15:0] map2 [2][25];
  logic signed [15:0] w2 [2][9];
  logic signed [15:0] out2 [9];
  logic dv1, busy1, dv2, busy2;
  int mx [2][25];
  int mw [2][9];
  bit relu;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  conv_multichannel d1 (
    .clk(clk), .reset(reset), .start(start1), .relu_en(relu1), .inputMAP(map1),
    .weights(w1), .outputMAP(out1), .data_valid(dv1), .busy(busy1)
  );
  conv_multichannel #(.CH(2)) d2 (
    .clk(clk), .reset(reset), .start(start2), .relu_en(relu2), .inputMAP(map2),
    .weights(w2), .outputMAP(out2), .data_valid(dv2), .busy(busy2)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint ref_pix(input int ch, input int p);
    longint s = 0;
    for (int c = 0; c < ch; c++)
      for (int ty = 0; ty < 3; ty++)
        for (int tx = 0; tx < 3; tx++)
          s += longint'(mx[c][(p / 3 + ty) * 5 + p % 3 + tx]) * longint'(mw[c][ty * 3 + tx]);
    s = s >>> 8;
    if (relu && s < 0) s = 0;
    return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
  endfunction
  task automatic apply();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 25; i++) map2[c][i] = 16'(mx[c][i]);
      for (int t = 0; t < 9; t++) w2[c][t] = 16'(mw[c][t]);
    end
    for (int i = 0; i < 25; i++) map1[0][i] = 16'(mx[0][i]);
    for (int t = 0; t < 9; t++) w1[0][t] = 16'(mw[0][t]);
    relu1 = relu;
    relu2 = relu;
  endtask
  task automatic fill(input int lo, input int hi, input int wlo, input int whi);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 25; i++) mx[c][i] = lo + int'($urandom_range(hi - lo, 0));
      for (int t = 0; t < 9; t++) mw[c][t] = wlo + int'($urandom_range(whi - wlo, 0));
    end
  endtask
  // Runs one operation; poke>0 re-pulses start with fresh random operands mid-run.
  task automatic go(input int which, input string tag, input int lat, input int poke);
    longint e [9];
    int n;
    bit dv;
    for (int p = 0; p < 9; p++) e[p] = ref_pix(which, p);
    apply();
    @(negedge clk);
    if (which == 1) start1 = 1; else start2 = 1;
    @(posedge clk);
    #1 start1 = 0;
    start2 = 0;
    chk({tag, ":busy"}, which == 1 ? busy1 : busy2, 1);
    n = 0;
    dv = 0;
    while (!dv && n < 1000) begin
      @(posedge clk);
      #1 n++;
      dv = which == 1 ? dv1 : dv2;
      if (poke > 0 && n == poke) begin
        fill(-32768, 32767, -32768, 32767);
        relu = ~relu;
        apply();
        if (which == 1) start1 = 1; else start2 = 1;
      end
      if (poke > 0 && n == poke + 1) begin
        start1 = 0;
        start2 = 0;
      end
    end
    chk({tag, ":lat"}, n, lat);
    for (int p = 0; p < 9; p++)
      chk($sformatf("%s:out[%0d]", tag, p), which == 1 ? out1[p] : out2[p], e[p]);
    chk({tag, ":busy_dv"}, which == 1 ? busy1 : busy2, 1);
    @(posedge clk);
    #1 chk({tag, ":dv_pulse"}, which == 1 ? dv1 : dv2, 0);
    chk({tag, ":idle"}, which == 1 ? busy1 : busy2, 0);
  endtask
  task automatic ramp();
    int wa [9] = '{0, 256, 512, 768, 1024, 1280, 1536, 1799, 2048};
    for (int i = 0; i < 25; i++) mx[0][i] = i;
    for (int t = 0; t < 9; t++) mw[0][t] = wa[t];
    relu = 0;
  endtask
  initial begin
    int cnt;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 25; i++) mx[c][i] = 0;
      for (int t = 0; t < 9; t++) mw[c][t] = 0;
    end
    relu = 0;
    apply();
    repeat (3) @(posedge clk);
    #1 chk("rst:busy", busy1, 0);
    chk("rst:dv", dv1, 0);
    for (int p = 0; p < 9; p++) chk($sformatf("rst:out[%0d]", p), out1[p], 0);
    @(negedge clk) reset = 1;
    ramp();
    go(1, "ramp", 91, 0);
    chk("ramp:first", out1[0], 312);
    for (int t = 0; t < 9; t++) mw[0][t] = t == 4 ? 256 : 0;
    go(1, "center", 91, 0);
    chk("center:mid", out1[4], 12);
    for (int i = 0; i < 25; i++) mx[0][i] = 1000;
    for (int t = 0; t < 9; t++) mw[0][t] = 2048;
    go(1, "sat_pos", 91, 0);
    chk("sat_pos:first", out1[0], 32767);
    for (int i = 0; i < 25; i++) mx[0][i] = -1000;
    go(1, "sat_neg", 91, 0);
    chk("sat_neg:first", out1[0], -32768);
    relu = 1;
    go(1, "relu", 91, 0);
    chk("relu:first", out1[0], 0);
    relu = 0;
    for (int i = 0; i < 25; i++) begin
      mx[0][i] = i;
      mx[1][i] = 1;
    end
    for (int t = 0; t < 9; t++) begin
      mw[0][t] = t == 4 ? 256 : 0;
      mw[1][t] = t == 4 ? 256 : 0;
    end
    go(2, "ch2", 172, 0);
    chk("ch2:first", out2[0], 7);
    ramp();
    go(1, "restart", 91, 20);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) fill(-2000, 2000, -512, 512);
      else fill(-32768, 32767, -32768, 32767);
      relu = 1'($urandom_range(1, 0));
      go(1, $sformatf("rnd1_%0d", k), 91, 0);
      go(2, $sformatf("rnd2_%0d", k), 172, 0);
    end
    ramp();
    apply();
    @(negedge clk) start1 = 1;
    @(negedge clk) start1 = 0;
    repeat (30) @(posedge clk);
    #3 reset = 0;
    #1 chk("abort:busy", busy1, 0);
    cnt = 0;
    for (int p = 0; p < 9; p++) cnt += out1[p] != 0 ? 1 : 0;
    chk("abort:nonzero_outs", cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    cnt = 0;
    repeat (120) begin
      @(posedge clk);
      #1 cnt += dv1 ? 1 : 0;
    end
    chk("abort:dv_count", cnt, 0);
    chk("abort:busy_after", busy1, 0);
    go(1, "post_rst", 91, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
